// File: rtl/lfsr_checker.sv
// Receive-side PRBS checker: self-syncs to a Galois LFSR word stream,
// then flywheels the predicted sequence and counts locked mismatches.
module lfsr_checker #(
  parameter int LEN = 8,
  parameter logic [LEN-1:0] TAPS = 8'b10111000,
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 3,
  parameter int ERR_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             valid,
  input  logic [LEN-1:0]   data,
  output logic             locked,
  output logic             mismatch,
  output logic             lock_lost,
  output logic [LEN-1:0]   expected,
  output logic [ERR_W-1:0] err_count
);

  localparam int RW = $clog2(LOCK_COUNT + 1);
  localparam int MW = $clog2(LOSS_COUNT + 1);

  localparam logic [1:0] SEEK    = 2'd0;
  localparam logic [1:0] ACQUIRE = 2'd1;
  localparam logic [1:0] LOCKED  = 2'd2;

  function automatic logic [LEN-1:0] step(input logic [LEN-1:0] x);
    step = {1'b0, x[LEN-1:1]} ^ (x[0] ? TAPS : '0);
  endfunction

  logic [1:0]    state;
  logic [RW-1:0] run;
  logic [MW-1:0] miss;
  logic [RW-1:0] run_nx;
  logic [MW-1:0] miss_nx;
  logic          hit;
  logic          nz;

  assign run_nx  = run + 1'b1;
  assign miss_nx = miss + 1'b1;
  assign hit     = (data == expected);
  assign nz      = (data != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= SEEK;
      expected  <= '0;
      run       <= '0;
      miss      <= '0;
      locked    <= 1'b0;
      mismatch  <= 1'b0;
      lock_lost <= 1'b0;
      err_count <= '0;
    end else begin
      mismatch  <= 1'b0;
      lock_lost <= 1'b0;
      if (valid) begin
        unique case (1'b1)
          (state == SEEK): begin
            if (nz) begin
              expected <= step(data);
              run      <= '0;
              state    <= ACQUIRE;
            end
          end
          (state == ACQUIRE): begin
            if (hit) begin
              expected <= step(data);
              if (run_nx == RW'(LOCK_COUNT)) begin
                state  <= LOCKED;
                locked <= 1'b1;
                miss   <= '0;
              end else begin
                run <= run_nx;
              end
            end else if (nz) begin
              run      <= '0;
              expected <= step(data);
            end else begin
              state <= SEEK;
            end
          end
          (state == LOCKED): begin
            if (hit) begin
              expected <= step(expected);
              miss     <= '0;
            end else begin
              mismatch <= 1'b1;
              if (err_count != '1)
                err_count <= err_count + 1'b1;
              // losing lock freezes the prediction at its last value
              if (miss_nx == MW'(LOSS_COUNT)) begin
                state     <= SEEK;
                locked    <= 1'b0;
                lock_lost <= 1'b1;
                miss      <= '0;
              end else begin
                miss     <= miss_nx;
                expected <= step(expected);
              end
            end
          end
          default: state <= SEEK;
        endcase
      end
      if (clear)
        err_count <= '0;
    end
  end

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker: lock, flywheel, loss,
// saturation/clear, zero words, async reset and valid gaps.
module tb_lfsr_checker;

  logic        clk;
  logic        rst;
  logic        c0, v0, c1, v1;
  logic [7:0]  d0, d1;
  logic        lk0, mm0, ll0;
  logic [7:0]  ex0;
  logic [15:0] er0;
  logic        lk1, mm1, ll1;
  logic [7:0]  ex1;
  logic [3:0]  er1;

  int errors = 0;
  int checks = 0;

  lfsr_checker u0 (
    .clk(clk), .rst(rst), .clear(c0), .valid(v0), .data(d0),
    .locked(lk0), .mismatch(mm0), .lock_lost(ll0),
    .expected(ex0), .err_count(er0)
  );

  lfsr_checker #(.ERR_W(4), .LOSS_COUNT(32)) u1 (
    .clk(clk), .rst(rst), .clear(c1), .valid(v1), .data(d1),
    .locked(lk1), .mismatch(mm1), .lock_lost(ll1),
    .expected(ex1), .err_count(er1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input int u, input logic [7:0] d,
                      input logic clr);
    @(negedge clk);
    if (u == 0) begin v0 = 1'b1; d0 = d; c0 = clr; end
    else begin v1 = 1'b1; d1 = d; c1 = clr; end
    @(posedge clk);
    #1;
    v0 = 1'b0; v1 = 1'b0; c0 = 1'b0; c1 = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      v0 = 1'b0; v1 = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b1;
    v0 = 0; d0 = 0; c0 = 0;
    v1 = 0; d1 = 0; c1 = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_locked", lk0, 0);
    chk("rst_exp", ex0, 0);
    chk("rst_err", er0, 0);
    chk("rst_pulses", {mm0, ll0}, 0);
    @(negedge clk);
    rst = 1'b0;

    repeat (5) send(0, 8'h00, 0);
    chk("zero_locked", lk0, 0);
    chk("zero_exp", ex0, 8'h00);

    send(0, 8'h01, 0);
    chk("seek_exp", ex0, 8'hB8);
    send(0, 8'hB8, 0);
    chk("acq_exp", ex0, 8'h5C);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("async_exp", ex0, 0);
    chk("async_out", {lk0, mm0, ll0, er0}, 0);
    @(negedge clk);
    rst = 1'b0;

    send(0, 8'h01, 0);
    chk("restart_exp", ex0, 8'hB8);
    send(0, 8'h5D, 0);
    chk("resync_exp", ex0, 8'h96);
    chk("resync_err", er0, 0);
    send(0, 8'h00, 0);
    send(0, 8'h01, 0);
    chk("reseek_exp", ex0, 8'hB8);
    send(0, 8'hB8, 0);
    send(0, 8'h5C, 0);
    send(0, 8'h2E, 0);
    chk("prelock", lk0, 0);
    send(0, 8'h17, 0);
    chk("lock", lk0, 1);
    chk("lock_exp", ex0, 8'hB3);
    chk("lock_err", er0, 0);

    send(0, 8'hB3, 0);
    chk("fly_exp1", ex0, 8'hE1);
    chk("fly_mm1", mm0, 0);
    send(0, 8'h00, 0);
    chk("fly_mm2", mm0, 1);
    chk("fly_err", er0, 1);
    chk("fly_lock", lk0, 1);
    chk("fly_exp2", ex0, 8'hC8);
    send(0, 8'hC8, 0);
    chk("fly_mm3", mm0, 0);
    chk("fly_exp3", ex0, 8'h64);

    idle(1);
    chk("gap1_exp", ex0, 8'h64);
    chk("gap1_st", {lk0, mm0}, 2'b10);
    send(0, 8'h64, 0);
    chk("gap_w1", ex0, 8'h32);
    idle(3);
    chk("gap3_exp", ex0, 8'h32);
    send(0, 8'h32, 0);
    chk("gap_w2", ex0, 8'h19);
    idle(5);
    chk("gap5_exp", ex0, 8'h19);
    chk("gap5_st", {lk0, mm0}, 2'b10);
    send(0, 8'h19, 0);
    chk("gap_w3", ex0, 8'hB4);
    chk("gap_mm", mm0, 0);

    send(0, 8'hFF, 0);
    chk("loss1", {lk0, mm0, ll0}, 3'b110);
    chk("loss1_err", er0, 2);
    chk("loss1_exp", ex0, 8'h5A);
    send(0, 8'hFF, 0);
    chk("loss2", {lk0, mm0, ll0}, 3'b110);
    chk("loss2_exp", ex0, 8'h2D);
    send(0, 8'hFF, 0);
    chk("loss3", {lk0, mm0, ll0}, 3'b011);
    chk("loss3_err", er0, 4);
    chk("loss3_exp", ex0, 8'h2D);
    idle(1);
    chk("loss_drop", {mm0, ll0}, 0);
    send(0, 8'h01, 0);
    send(0, 8'hB8, 0);
    send(0, 8'h5C, 0);
    send(0, 8'h2E, 0);
    send(0, 8'h17, 0);
    chk("relock", lk0, 1);
    chk("relock_exp", ex0, 8'hB3);
    chk("relock_err", er0, 4);

    send(0, 8'h00, 0);
    chk("pre_clr_err", er0, 5);
    send(0, 8'h00, 1);
    chk("clr_mm", mm0, 1);
    chk("clr_err", er0, 0);
    chk("clr_exp", ex0, 8'hC8);
    send(0, 8'hC8, 0);
    chk("clr_after", {lk0, mm0, er0}, {1'b1, 1'b0, 16'd0});

    send(1, 8'h01, 0);
    send(1, 8'hB8, 0);
    send(1, 8'h5C, 0);
    send(1, 8'h2E, 0);
    send(1, 8'h17, 0);
    chk("sat_lock", lk1, 1);
    repeat (14) send(1, 8'h00, 0);
    chk("sat_14", er1, 4'hE);
    send(1, 8'h00, 0);
    chk("sat_15", er1, 4'hF);
    repeat (5) send(1, 8'h00, 0);
    chk("sat_20", er1, 4'hF);
    chk("sat_locked", {lk1, ll1}, 2'b10);
    send(1, 8'h00, 1);
    chk("sat_clr", {mm1, er1}, {1'b1, 4'h0});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
